mem_port_arbiter: RTL and testbench

Two-port arbiter that shares the single-ported 16x16 data memory of the memory stage between the pipeline's memory access (port 0) and a loader/debug requester (port 1). Each port uses a valid/ready handshake. The arbiter owns the memory address, write-data and write-enable lines and returns registered read data per port. Ownership is round-robin, with an optional locked burst capped at MAX_BURST accesses.

---
 rtl/mem_port_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin two-port arbiter for the single-ported data memory
module mem_port_arbiter #(
    parameter int DW        = 16,
    parameter int AW        = 4,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0_i,
    input  logic          wr0_i,
    input  logic          lock0_i,
    input  logic [AW-1:0] addr0_i,
    input  logic [DW-1:0] wdata0_i,
    input  logic          req1_i,
    input  logic          wr1_i,
    input  logic          lock1_i,
    input  logic [AW-1:0] addr1_i,
    input  logic [DW-1:0] wdata1_i,
    output logic          gnt0_o,
    output logic          gnt1_o,
    output logic          rvalid0_o,
    output logic          rvalid1_o,
    output logic [DW-1:0] rdata0_o,
    output logic [DW-1:0] rdata1_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wd_o,
    output logic          mem_we_o,
    input  logic [DW-1:0] mem_rd_i
);

    localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          rvalid0_q, rvalid1_q;
    logic [DW-1:0] rdata0_q, rdata1_q;
    logic          fire0, fire1;

    assign gnt0_o    = (state_q == OWN0);
    assign gnt1_o    = (state_q == OWN1);
    assign fire0     = req0_i & gnt0_o;
    assign fire1     = req1_i & gnt1_o;
    assign rvalid0_o = rvalid0_q;
    assign rvalid1_o = rvalid1_q;
    assign rdata0_o  = rdata0_q;
    assign rdata1_o  = rdata1_q;

    // The owner's payload drives memory; IDLE drives all-zero so nothing is written.
    always_comb begin
        mem_addr_o = '0;
        mem_wd_o   = '0;
        mem_we_o   = 1'b0;
        case (state_q)
            OWN0: begin
                mem_addr_o = addr0_i;
                mem_wd_o   = wdata0_i;
                mem_we_o   = fire0 & wr0_i;
            end
            OWN1: begin
                mem_addr_o = addr1_i;
                mem_wd_o   = wdata1_i;
                mem_we_o   = fire1 & wr1_i;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            rvalid0_q <= fire0 & ~wr0_i;
            rvalid1_q <= fire1 & ~wr1_i;
            if (fire0 && !wr0_i) rdata0_q <= mem_rd_i;
            if (fire1 && !wr1_i) rdata1_q <= mem_rd_i;

            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (req0_i)      state_q <= OWN0;
                    else if (req1_i) state_q <= OWN1;
                end
                OWN0: begin
                    if (fire0) begin
                        if (lock0_i && cnt_q < CNT_LAST) begin
                            cnt_q <= cnt_q + 1'b1;
                        end else begin
                            cnt_q <= '0;
                            if (req1_i) state_q <= OWN1;
                        end
                    end else if (req1_i) begin
                        cnt_q   <= '0;
                        state_q <= OWN1;
                    end
                end
                OWN1: begin
                    if (fire1) begin
                        if (lock1_i && cnt_q < CNT_LAST) begin
                            cnt_q <= cnt_q + 1'b1;
                        end else begin
                            cnt_q <= '0;
                            if (req0_i) state_q <= OWN0;
                        end
                    end else if (req0_i) begin
                        cnt_q   <= '0;
                        state_q <= OWN0;
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter with a behavioural 16x16 memory
module tb_mem_port_arbiter;

    typedef struct packed {
        logic        wr;
        logic        lock;
        logic [3:0]  addr;
        logic [15:0] data;
    } op_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_i = 1'b0, wr0_i = 1'b0, lock0_i = 1'b0;
    logic        req1_i = 1'b0, wr1_i = 1'b0, lock1_i = 1'b0;
    logic [3:0]  addr0_i = '0, addr1_i = '0;
    logic [15:0] wdata0_i = '0, wdata1_i = '0;
    logic        gnt0_o, gnt1_o, rvalid0_o, rvalid1_o, mem_we_o;
    logic [15:0] rdata0_o, rdata1_o, mem_wd_o, mem_rd_i;
    logic [3:0]  mem_addr_o;

    logic [15:0] mem [16];
    logic [15:0] ref_mem [16];

    op_t         q0[$], q1[$];
    op_t         cur0, cur1;
    logic        have0 = 1'b0, have1 = 1'b0;
    logic [15:0] sb0[$], sb1[$];
    logic        pend0 = 1'b0, pend1 = 1'b0;
    logic        fire0_s = 1'b0, fire1_s = 1'b0;
    int          fire_port[$], fire_cyc[$];
    int          cyc = 0, we_cnt = 0, rv1_cnt = 0;
    int          n_chk = 0, n_pass = 0;

    mem_port_arbiter #(.DW(16), .AW(4), .MAX_BURST(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_i(req0_i), .wr0_i(wr0_i), .lock0_i(lock0_i), .addr0_i(addr0_i), .wdata0_i(wdata0_i),
        .req1_i(req1_i), .wr1_i(wr1_i), .lock1_i(lock1_i), .addr1_i(addr1_i), .wdata1_i(wdata1_i),
        .gnt0_o(gnt0_o), .gnt1_o(gnt1_o), .rvalid0_o(rvalid0_o), .rvalid1_o(rvalid1_o),
        .rdata0_o(rdata0_o), .rdata1_o(rdata1_o),
        .mem_addr_o(mem_addr_o), .mem_wd_o(mem_wd_o), .mem_we_o(mem_we_o), .mem_rd_i(mem_rd_i)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem[i]     = '0;
            ref_mem[i] = '0;
        end
    end

    assign mem_rd_i = mem[mem_addr_o];
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (mem_we_o) mem[mem_addr_o] <= mem_wd_o;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    endtask

    // Request drivers: hold the head op until it is seen to fire, then present the next.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (fire0_s) have0 = 1'b0;
            if (fire1_s) have1 = 1'b0;
            if (!have0 && q0.size() > 0) begin cur0 = q0.pop_front(); have0 = 1'b1; end
            if (!have1 && q1.size() > 0) begin cur1 = q1.pop_front(); have1 = 1'b1; end
            req0_i = have0; wr0_i = have0 & cur0.wr; lock0_i = have0 & cur0.lock;
            addr0_i = have0 ? cur0.addr : 4'h0; wdata0_i = have0 ? cur0.data : 16'h0;
            req1_i = have1; wr1_i = have1 & cur1.wr; lock1_i = have1 & cur1.lock;
            addr1_i = have1 ? cur1.addr : 4'h0; wdata1_i = have1 ? cur1.data : 16'h0;
        end
    end

    // Monitor and scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        logic f0, f1;
        if (!rst_n) begin
            check("rst_gnt", {gnt1_o, gnt0_o}, 0);
            check("rst_rvalid", {rvalid1_o, rvalid0_o}, 0);
            check("rst_we", mem_we_o, 0);
            pend0 = 1'b0; pend1 = 1'b0;
            fire0_s = 1'b0; fire1_s = 1'b0;
            sb0.delete(); sb1.delete();
        end else begin
            check("gnt_onehot", gnt0_o & gnt1_o, 0);
            check("rvalid0", rvalid0_o, pend0);
            check("rvalid1", rvalid1_o, pend1);
            if (rvalid1_o) rv1_cnt++;
            if (rvalid0_o && sb0.size() > 0) check("rdata0", rdata0_o, sb0.pop_front());
            if (rvalid1_o && sb1.size() > 0) check("rdata1", rdata1_o, sb1.pop_front());
            f0 = req0_i & gnt0_o;
            f1 = req1_i & gnt1_o;
            if (f0) begin
                fire_port.push_back(0); fire_cyc.push_back(cyc);
                check("addr0", mem_addr_o, addr0_i);
                check("we0", mem_we_o, wr0_i);
                if (wr0_i) begin
                    check("wd0", mem_wd_o, wdata0_i);
                    ref_mem[addr0_i] = wdata0_i;
                end else sb0.push_back(ref_mem[addr0_i]);
            end
            if (f1) begin
                fire_port.push_back(1); fire_cyc.push_back(cyc);
                check("addr1", mem_addr_o, addr1_i);
                check("we1", mem_we_o, wr1_i);
                if (wr1_i) begin
                    check("wd1", mem_wd_o, wdata1_i);
                    ref_mem[addr1_i] = wdata1_i;
                end else sb1.push_back(ref_mem[addr1_i]);
            end
            if (!f0 && !f1) check("we_idle", mem_we_o, 0);
            if (mem_we_o) we_cnt++;
            pend0 = f0 & ~wr0_i;
            pend1 = f1 & ~wr1_i;
            fire0_s = f0;
            fire1_s = f1;
        end
    end

    task automatic drain();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk); #2;
            if (q0.size() == 0 && q1.size() == 0 && !have0 && !have1 && !pend0 && !pend1) begin
                ok = 1'b1;
                break;
            end
        end
        check("drain", ok, 1);
        repeat (2) @(negedge clk);
        #2;
    endtask

    task automatic clear_log();
        fire_port.delete();
        fire_cyc.delete();
        we_cnt = 0;
    endtask

    task automatic check_order(input string tag, input int exp[]);
        check({tag, "_len"}, fire_port.size(), exp.size());
        for (int i = 0; i < exp.size() && i < fire_port.size(); i++)
            check(tag, fire_port[i], exp[i]);
    endtask

    task automatic reset_pulse();
        @(negedge clk); #1 rst_n = 1'b0;
        @(negedge clk); #1 rst_n = 1'b1;
        #1;
    endtask

    initial begin
        int k;
        int rv_before;
        logic ok;

        // Reset with a pending request on port 0
        q0.push_back('{wr: 1'b0, lock: 1'b0, addr: 4'd0, data: 16'h0});
        repeat (2) @(negedge clk);
        #2;
        check("rst_gnt0", gnt0_o, 0);
        check("rst_addr", mem_addr_o, 0);
        check("rst_wd", mem_wd_o, 0);
        check("rst_rdata0", rdata0_o, 0);
        check("rst_rdata1", rdata1_o, 0);
        @(negedge clk); #1 rst_n = 1'b1;
        @(negedge clk); #2;
        check("gnt0_after_rst", gnt0_o, 1);
        drain();

        // Write then read on port 0
        clear_log();
        q0.push_back('{wr: 1'b1, lock: 1'b0, addr: 4'd5, data: 16'hBEEF});
        q0.push_back('{wr: 1'b0, lock: 1'b0, addr: 4'd5, data: 16'h0});
        drain();
        check_order("wr_rd_order", '{0, 0});
        check("wr_we_cycles", we_cnt, 1);
        check("rdata0_beef", rdata0_o, 16'hBEEF);

        // Park: port 1 writes back-to-back
        clear_log();
        q1.push_back('{wr: 1'b1, lock: 1'b0, addr: 4'd1, data: 16'h0011});
        q1.push_back('{wr: 1'b1, lock: 1'b0, addr: 4'd2, data: 16'h0022});
        q1.push_back('{wr: 1'b1, lock: 1'b0, addr: 4'd3, data: 16'h0033});
        drain();
        check_order("park_order", '{1, 1, 1});
        check("park_we_cycles", we_cnt, 3);
        for (int i = 0; i + 1 < fire_cyc.size(); i++)
            check("park_gap", fire_cyc[i+1] - fire_cyc[i], 1);

        // Contention from IDLE without lock
        reset_pulse();
        clear_log();
        for (int i = 0; i < 6; i++) begin
            q0.push_back('{wr: 1'b0, lock: 1'b0, addr: 4'(i),     data: 16'h0});
            q1.push_back('{wr: 1'b0, lock: 1'b0, addr: 4'(i + 1), data: 16'h0});
        end
        drain();
        check_order("rr_order", '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1});

        // Locked burst from port 1 (currently parked on port 1) against port 0
        clear_log();
        for (int i = 0; i < 6; i++)
            q1.push_back('{wr: 1'b0, lock: 1'b1, addr: 4'(i), data: 16'h0});
        q0.push_back('{wr: 1'b0, lock: 1'b0, addr: 4'd5, data: 16'h0});
        q0.push_back('{wr: 1'b0, lock: 1'b0, addr: 4'd2, data: 16'h0});
        drain();
        check_order("lock_order", '{1, 1, 1, 1, 0, 1, 1, 0});

        // Asynchronous reset during a port 1 read
        clear_log();
        rv_before = rv1_cnt;
        q1.push_back('{wr: 1'b0, lock: 1'b0, addr: 4'd2, data: 16'h0});
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #2;
            if (fire1_s) begin ok = 1'b1; break; end
        end
        check("rst_mid_fire_seen", ok, 1);
        @(posedge clk); #1 rst_n = 1'b0;
        @(negedge clk); #2;
        check("rst_mid_rvalid1", rvalid1_o, 0);
        check("rst_mid_gnt1", gnt1_o, 0);
        @(negedge clk); #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        check("post_rst_idle", {gnt1_o, gnt0_o}, 0);
        check("rvalid1_lost", rv1_cnt, rv_before);
        clear_log();
        k = cyc;
        q0.push_back('{wr: 1'b0, lock: 1'b0, addr: 4'd3, data: 16'h0});
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #2;
            if (fire_cyc.size() > 0) begin ok = 1'b1; break; end
        end
        check("post_rst_fire_seen", ok, 1);
        if (ok) check("post_rst_latency", fire_cyc[0] - k, 2);
        drain();
        check("post_rst_rdata0", rdata0_o, 16'h0033);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=%0d exp=0", cyc);
        $fatal(1, "timeout");
    end

endmodule
